// File: rtl/fu_br_multi.sv
// N-lane branch resolution unit: oldest-mispredict redirect plus a predictor-update FIFO.
// Optional statistics counters are built when FU_BR_STATS_EN is defined.
module fu_br_multi #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned UPD_DEPTH = 4,
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     ex_valid,
    input  logic [LANES*32-1:0]  ex_pc,
    input  logic [LANES*32-1:0]  ex_rdata1,
    input  logic [LANES*32-1:0]  ex_rdata2,
    input  logic [LANES*32-1:0]  ex_imm,
    input  logic [LANES*4-1:0]   ex_br_type,
    input  logic [LANES-1:0]     ex_pd_taken,
    input  logic [LANES*32-1:0]  ex_pd_pc,
    input  logic [LANES*2-1:0]   ex_pd_type,
    input  logic                 stall,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [LW-1:0]        redirect_lane,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [31:0]          upd_pc,
    output logic [1:0]           upd_type,
    output logic [31:0]          upd_target,
    output logic                 upd_taken,
    output logic [7:0]           upd_drop_cnt,
    output logic [31:0]          stat_br_cnt,
    output logic [31:0]          stat_mp_cnt
);

    localparam int unsigned PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 67;

    logic [LANES-1:0] taken, mp, pd_br;
    logic [31:0]      cor_pc [LANES];
    logic [EW-1:0]    entry  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] pc, rs1, rs2, imm, pd_pc, tgt;
        logic [3:0]  bt;
        logic        lane_taken, is_br;

        assign pc    = ex_pc[32*g +: 32];
        assign rs1   = ex_rdata1[32*g +: 32];
        assign rs2   = ex_rdata2[32*g +: 32];
        assign imm   = ex_imm[32*g +: 32];
        assign pd_pc = ex_pd_pc[32*g +: 32];
        assign bt    = ex_br_type[4*g +: 4];

        always_comb begin
            lane_taken = 1'b0;
            case (bt)
                4'd1, 4'd2, 4'd3: lane_taken = 1'b1;
                4'd4:             lane_taken = (rs1 == rs2);
                4'd5:             lane_taken = (rs1 != rs2);
                4'd6:             lane_taken = ($signed(rs1) < $signed(rs2));
                4'd7:             lane_taken = ($signed(rs1) >= $signed(rs2));
                4'd8:             lane_taken = (rs1 < rs2);
                4'd9:             lane_taken = (rs1 >= rs2);
                default:          lane_taken = 1'b0;
            endcase
        end

        assign tgt       = (bt == 4'd1) ? rs1 + imm : pc + imm;
        assign is_br     = (bt >= 4'd1) && (bt <= 4'd9);
        assign taken[g]  = lane_taken;
        assign mp[g]     = ex_valid[g] & is_br &
                           ((ex_pd_taken[g] != lane_taken) | (lane_taken & (pd_pc != tgt)));
        assign cor_pc[g] = lane_taken ? tgt : pc + 32'd4;
        assign entry[g]  = {pc, ex_pd_type[2*g +: 2], tgt, lane_taken};
        assign pd_br[g]  = ex_valid[g] & (ex_pd_type[2*g +: 2] != 2'b00);
    end

    logic          mp_any, cand_any;
    logic [LW-1:0] win, cand;

    // Descending scan leaves the lowest (oldest) matching lane selected.
    always_comb begin
        mp_any = 1'b0;
        win    = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (mp[i]) begin
                mp_any = 1'b1;
                win    = LW'(i);
            end
        end
    end

    always_comb begin
        cand_any = 1'b0;
        cand     = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (pd_br[i] && (!mp_any || (LW'(i) <= win))) begin
                cand_any = 1'b1;
                cand     = LW'(i);
            end
        end
    end

    logic fired_q, fired_d, pushed_q, pushed_d;
    logic push, pop, full, push_ok, drop;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    drop_q, drop_d;
    logic [EW-1:0] mem [UPD_DEPTH];

    assign redirect      = mp_any & ~fired_q & ~rst;
    assign redirect_pc   = mp_any ? cor_pc[win] : 32'd0;
    assign redirect_lane = win;

    assign push    = cand_any & ~(fired_q | pushed_q);
    assign upd_valid = (cnt_q != '0);
    assign pop     = upd_valid & upd_ready;
    assign full    = (cnt_q == CW'(UPD_DEPTH));
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Flags survive only while the same bundle is held in EX.
    assign fired_d  = stall & (redirect | fired_q);
    assign pushed_d = stall & (push | pushed_q);

    always_comb begin
        wr_d   = push_ok ? wr_q + PW'(1) : wr_q;
        rd_d   = pop ? rd_q + PW'(1) : rd_q;
        cnt_d  = cnt_q;
        if (push_ok && !pop) cnt_d = cnt_q + CW'(1);
        if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fired_q  <= 1'b0;
            pushed_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            fired_q  <= fired_d;
            pushed_q <= pushed_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= entry[cand];
    end

    assign {upd_pc, upd_type, upd_target, upd_taken} = upd_valid ? mem[rd_q] : '0;
    assign upd_drop_cnt = drop_q;

`ifdef FU_BR_STATS_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (push_ok)  br_cnt_q <= br_cnt_q + 32'd1;
            if (redirect) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign stat_br_cnt = br_cnt_q;
    assign stat_mp_cnt = mp_cnt_q;
`else
    assign stat_br_cnt = 32'd0;
    assign stat_mp_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fu_br_multi.sv
// Directed bench for fu_br_multi (LANES=2, UPD_DEPTH=4) with hand-computed expectations.
module tb_fu_br_multi;

    logic        clk;
    logic        rst;
    logic [1:0]  ex_valid;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_pd_pc;
    logic [7:0]  ex_br_type;
    logic [1:0]  ex_pd_taken;
    logic [3:0]  ex_pd_type;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [0:0]  redirect_lane;
    logic        upd_valid, upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [7:0]  upd_drop_cnt;
    logic [31:0] stat_br_cnt, stat_mp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fu_br_multi #(.LANES(2), .UPD_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rdata1    (ex_rdata1),
        .ex_rdata2    (ex_rdata2),
        .ex_imm       (ex_imm),
        .ex_br_type   (ex_br_type),
        .ex_pd_taken  (ex_pd_taken),
        .ex_pd_pc     (ex_pd_pc),
        .ex_pd_type   (ex_pd_type),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .redirect_lane(redirect_lane),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_type     (upd_type),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .upd_drop_cnt (upd_drop_cnt),
        .stat_br_cnt  (stat_br_cnt),
        .stat_mp_cnt  (stat_mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        ex_valid    = '0;
        ex_pc       = '0;
        ex_rdata1   = '0;
        ex_rdata2   = '0;
        ex_imm      = '0;
        ex_br_type  = '0;
        ex_pd_taken = '0;
        ex_pd_pc    = '0;
        ex_pd_type  = '0;
    endtask

    task automatic set_lane(input int ln, input logic [31:0] pc, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] imm, input logic [3:0] bt,
                            input logic pdt, input logic [31:0] pdpc, input logic [1:0] pdty);
        ex_valid[ln]          = 1'b1;
        ex_pc[32*ln +: 32]     = pc;
        ex_rdata1[32*ln +: 32] = r1;
        ex_rdata2[32*ln +: 32] = r2;
        ex_imm[32*ln +: 32]    = imm;
        ex_br_type[4*ln +: 4]  = bt;
        ex_pd_taken[ln]       = pdt;
        ex_pd_pc[32*ln +: 32]  = pdpc;
        ex_pd_type[2*ln +: 2]  = pdty;
    endtask

    task automatic pop_one();
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] exp_pc [4];

    initial begin
        clear_lanes();
        stall     = 1'b0;
        upd_ready = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_upd_valid", upd_valid, 0);
        check("rst_redirect", redirect, 0);
        check("rst_drop", upd_drop_cnt, 0);
        check("rst_upd_pc", upd_pc, 0);

        // Lane0 BEQ taken, predicted not taken
        set_lane(0, 32'h1000, 5, 5, 32'h20, 4'd4, 1'b0, 0, 2'd1);
        #1;
        check("beq_redirect", redirect, 1);
        check("beq_redirect_pc", redirect_pc, 32'h1020);
        check("beq_lane", redirect_lane, 0);
        tick();
        clear_lanes();
        #1;
        check("beq_upd_valid", upd_valid, 1);
        check("beq_upd_target", upd_target, 32'h1020);
        check("beq_upd_taken", upd_taken, 1);
        check("beq_upd_pc", upd_pc, 32'h1000);
        pop_one();
        check("beq_drained", upd_valid, 0);

        // Lane0 BNE correctly not taken, lane1 JIRL to wrong predicted target
        set_lane(0, 32'h2000, 1, 1, 32'h40, 4'd5, 1'b0, 0, 2'd1);
        set_lane(1, 32'h2004, 32'h8000, 0, 4, 4'd1, 1'b1, 32'h9000, 2'd2);
        #1;
        check("jirl_redirect", redirect, 1);
        check("jirl_lane", redirect_lane, 1);
        check("jirl_redirect_pc", redirect_pc, 32'h8004);
        tick();
        clear_lanes();
        #1;
        check("jirl_upd_pc", upd_pc, 32'h2000);
        check("jirl_upd_type", upd_type, 1);
        check("jirl_upd_target", upd_target, 32'h2040);
        check("jirl_upd_taken", upd_taken, 0);
        pop_one();
        check("jirl_single_push", upd_valid, 0);

        // Both lanes mispredict: lane0 wins, lane1 squashed
        set_lane(0, 32'h3000, 0, 0, 32'h100, 4'd2, 1'b0, 0, 2'd3);
        set_lane(1, 32'h3004, 1, 2, 8, 4'd4, 1'b1, 32'h300C, 2'd1);
        #1;
        check("both_redirect_pc", redirect_pc, 32'h3100);
        check("both_lane", redirect_lane, 0);
        tick();
        clear_lanes();
        #1;
        check("both_upd_pc", upd_pc, 32'h3000);
        check("both_upd_type", upd_type, 3);
        pop_one();
        check("both_squashed", upd_valid, 0);
        check("both_drop", upd_drop_cnt, 0);

        // BLT mispredict held for 5 stalled cycles
        stall = 1'b1;
        set_lane(0, 32'h4000, 32'hFFFF_FFFF, 1, 32'h10, 4'd6, 1'b0, 0, 2'd1);
        #1;
        check("stall_c1_redirect", redirect, 1);
        check("stall_c1_pc", redirect_pc, 32'h4010);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("stall_c%0d_redirect", c), redirect, 0);
        end
        tick();
        stall = 1'b0;
        clear_lanes();
        upd_ready = 1'b1;
        #1;
        check("stall_upd_pc", upd_pc, 32'h4000);
        tick();
        upd_ready = 1'b0;
        check("stall_one_push", upd_valid, 0);
        // New bundle: BLTU not taken but predicted taken
        set_lane(0, 32'h5000, 32'hFFFF_FFFF, 1, 32'h10, 4'd8, 1'b1, 32'h5010, 2'd1);
        #1;
        check("bltu_redirect", redirect, 1);
        check("bltu_redirect_pc", redirect_pc, 32'h5004);
        tick();
        clear_lanes();
        #1;
        check("bltu_upd_taken", upd_taken, 0);
        check("bltu_upd_target", upd_target, 32'h5010);
        pop_one();

        // Five correct branches into a 4-deep FIFO with no draining
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 32'h6000 + 32'(k) * 16, 0, 0, 8, 4'd2, 1'b1,
                     32'h6008 + 32'(k) * 16, 2'd3);
            tick();
        end
        clear_lanes();
        #1;
        check("full_redirect", redirect, 0);
        check("full_drop", upd_drop_cnt, 1);
        check("full_head", upd_pc, 32'h6000);
        set_lane(0, 32'h7000, 0, 0, 8, 4'd2, 1'b1, 32'h7008, 2'd3);
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        clear_lanes();
        #1;
        check("pushpop_drop", upd_drop_cnt, 1);
        exp_pc[0] = 32'h6010;
        exp_pc[1] = 32'h6020;
        exp_pc[2] = 32'h6030;
        exp_pc[3] = 32'h7000;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_%0d_valid", k), upd_valid, 1);
            check($sformatf("drain_%0d_pc", k), upd_pc, exp_pc[k]);
            pop_one();
        end
        check("drain_empty", upd_valid, 0);

        // Reset mid-stall with three entries queued
        set_lane(0, 32'hA000, 0, 0, 8, 4'd2, 1'b1, 32'hA008, 2'd3);
        tick();
        set_lane(0, 32'hA010, 0, 0, 8, 4'd2, 1'b1, 32'hA018, 2'd3);
        tick();
        stall = 1'b1;
        set_lane(0, 32'hB000, 1, 32'hFFFF_FFFF, 32'h20, 4'd7, 1'b0, 0, 2'd1);
        #1;
        check("rs_redirect", redirect, 1);
        check("rs_redirect_pc", redirect_pc, 32'hB020);
        tick();
        check("rs_held", redirect, 0);
        check("rs_upd_pc", upd_pc, 32'hA000);
        rst = 1'b1;
        #1;
        check("rs_rst_gate", redirect, 0);
        tick();
        check("rs_upd_valid", upd_valid, 0);
        check("rs_redirect_after", redirect, 0);
        check("rs_drop", upd_drop_cnt, 0);
        check("rs_upd_pc_zero", upd_pc, 0);
        check("rs_stat_br", stat_br_cnt, 0);
        check("rs_stat_mp", stat_mp_cnt, 0);
        rst   = 1'b0;
        stall = 1'b0;
        clear_lanes();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
